// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential calculator ALU.
// Holds the opcode encodings, the FSM state type and the fixed
// percent divisor used by the pct operation.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_POW = 3'b100;
    localparam logic [2:0] OP_PCT = 3'b101;

    localparam int PCT_DIVISOR = 100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_POW,
        ST_FIN
    } state_t;

endpackage

// File: rtl/seq_div_core.sv
// Restoring divider, one quotient bit per clock, exactly N iterations.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   start         - load dividend/divisor and begin (restarts if running)
//   dividend      - N-bit dividend
//   divisor       - N-bit divisor (must be non-zero; caller handles zero)
//   quotient      - N-bit quotient, final after the last iteration edge
//   remainder     - N-bit remainder, final after the last iteration edge
//   done          - high during the cycle whose closing edge performs the
//                   final iteration, so a caller can advance in lock-step
module seq_div_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  dvs_reg;
    logic [CW-1:0] cnt_reg;
    logic          running_reg;
    logic [N:0]    shifted;
    logic [N:0]    diff;

    // Quotient register doubles as the dividend shift register.
    assign shifted = {remainder, quotient[N-1]};
    assign diff    = shifted - {1'b0, dvs_reg};
    assign done    = running_reg && (cnt_reg == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient    <= '0;
            remainder   <= '0;
            dvs_reg     <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
        end else if (start) begin
            quotient    <= dividend;
            remainder   <= '0;
            dvs_reg     <= divisor;
            cnt_reg     <= CW'(N);
            running_reg <= 1'b1;
        end else if (running_reg) begin
            // Negative trial difference means restore (keep shifted value).
            if (!diff[N]) begin
                remainder <= diff[N-1:0];
                quotient  <= {quotient[N-2:0], 1'b1};
            end else begin
                remainder <= shifted[N-1:0];
                quotient  <= {quotient[N-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                running_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle calculator ALU: add, sub, div, mul, pow, pct behind a
// start/busy/done handshake.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   start         - operation request, sampled only in IDLE
//   a, b          - W-bit operands (A/base/dividend, B/exponent/divisor)
//   opcode        - operation select
//   busy          - high from the edge after acceptance until done clears
//   done          - one-cycle pulse when result/flags update
//   result        - RW-bit result, held until the next accepted start
//   ovf           - sub borrow or pow overflow
//   dz            - div by zero
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W  = 4,
    parameter int RW = 2 * W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [2:0]    opcode,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] result,
    output logic          ovf,
    output logic          dz
);

    localparam logic [RW-1:0] PCT_DIV_RW = RW'(PCT_DIVISOR);

    state_t        state_reg;
    logic [2:0]    op_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  cnt_reg;
    logic [RW-1:0] prod_reg;
    logic [RW-1:0] mcand_reg;
    logic [W-1:0]  mplier_reg;
    logic [RW-1:0] acc_reg;
    logic          povf_reg;

    logic [RW-1:0]   ax;
    logic [RW-1:0]   bx;
    logic [RW-1:0]   prod_next;
    logic [RW+W-1:0] pow_full;

    logic          div_start;
    logic [RW-1:0] div_dividend;
    logic [RW-1:0] div_divisor;
    logic [RW-1:0] div_quotient;
    logic [RW-1:0] div_rem_unused;
    logic          div_done;

    assign ax        = {{(RW-W){1'b0}}, a_reg};
    assign bx        = {{(RW-W){1'b0}}, b_reg};
    assign prod_next = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign pow_full  = {{W{1'b0}}, acc_reg} * {{RW{1'b0}}, a_reg};

    // The divider is launched either straight from IDLE (div, live operands)
    // or on the last multiply step of pct, fed with the product that step
    // completes so no extra cycle is spent between the two phases.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = {{(RW-W){1'b0}}, a};
        div_divisor  = {{(RW-W){1'b0}}, b};
        if (state_reg == ST_IDLE) begin
            div_start = start && (opcode == OP_DIV) && (b != '0);
        end else begin
            div_dividend = prod_next;
            div_divisor  = PCT_DIV_RW;
            div_start    = (state_reg == ST_MUL) && (op_reg == OP_PCT)
                           && (cnt_reg == W'(1));
        end
    end

    seq_div_core #(.N(RW)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .quotient  (div_quotient),
        .remainder (div_rem_unused),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            prod_reg   <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            povf_reg   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            dz         <= 1'b0;
        end else begin
            done <= 1'b0;
            // busy lags the state by one edge so it also covers the done cycle.
            busy <= (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg     <= opcode;
                        a_reg      <= a;
                        b_reg      <= b;
                        ovf        <= 1'b0;
                        dz         <= 1'b0;
                        povf_reg   <= 1'b0;
                        prod_reg   <= '0;
                        mcand_reg  <= {{(RW-W){1'b0}}, a};
                        mplier_reg <= b;
                        acc_reg    <= RW'(1);
                        cnt_reg    <= W'(W);
                        case (opcode)
                            OP_MUL, OP_PCT: state_reg <= ST_MUL;
                            OP_DIV: state_reg <= (b == '0) ? ST_FIN : ST_DIV;
                            OP_POW: begin
                                cnt_reg   <= b;
                                state_reg <= (b == '0) ? ST_FIN : ST_POW;
                            end
                            default: state_reg <= ST_FIN;
                        endcase
                    end
                end
                ST_MUL: begin
                    prod_reg   <= prod_next;
                    mcand_reg  <= {mcand_reg[RW-2:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[W-1:1]};
                    cnt_reg    <= cnt_reg - W'(1);
                    if (cnt_reg == W'(1)) begin
                        state_reg <= (op_reg == OP_PCT) ? ST_DIV : ST_FIN;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_reg <= ST_FIN;
                    end
                end
                ST_POW: begin
                    acc_reg <= pow_full[RW-1:0];
                    if (pow_full[RW+W-1:RW] != '0) begin
                        povf_reg <= 1'b1;
                    end
                    cnt_reg <= cnt_reg - W'(1);
                    if (cnt_reg == W'(1)) begin
                        state_reg <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b1;
                    state_reg <= ST_IDLE;
                    case (op_reg)
                        OP_ADD: result <= ax + bx;
                        OP_SUB: begin
                            result <= ax - bx;
                            ovf    <= (a_reg < b_reg);
                        end
                        OP_DIV: begin
                            if (b_reg == '0) begin
                                result <= '1;
                                dz     <= 1'b1;
                            end else begin
                                result <= div_quotient;
                            end
                        end
                        OP_MUL: result <= prod_reg;
                        OP_POW: begin
                            result <= acc_reg;
                            ovf    <= povf_reg;
                        end
                        OP_PCT: result <= div_quotient;
                        default: result <= '0;
                    endcase
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (W=4, RW=8): stimulus pushes expected
// responses, a negedge monitor pops and compares on every done pulse.
module tb_seq_alu;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opcode;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       ovf;
    logic       dz;

    seq_alu #(.W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .dz     (dz)
    );

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       ovf;
        logic       dz;
        int         lat;
        int         e0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    bit   prev_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (busy) busy_cnt++;
            if (prev_done) chk("done_pulse_width", int'(done), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done_queue", 0, 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk({mon_e.name, "_result"}, int'(result), int'(mon_e.res));
                    chk({mon_e.name, "_ovf"}, int'(ovf), int'(mon_e.ovf));
                    chk({mon_e.name, "_dz"}, int'(dz), int'(mon_e.dz));
                    chk({mon_e.name, "_latency"}, cyc - mon_e.e0, mon_e.lat);
                    chk({mon_e.name, "_busy_cycles"}, busy_cnt, mon_e.lat);
                    $display("op %s: result=%0d ovf=%0d dz=%0d latency=%0d",
                             mon_e.name, result, ovf, dz, cyc - mon_e.e0);
                end
                busy_cnt = 0;
            end
            prev_done = done;
        end else begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end
    end

    // Issue one operation (called just after a negedge) and wait for done.
    // With intf set, a conflicting start with new operands is pulsed mid-run.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] er, input logic eo, input logic ed,
                          input int lat, input bit intf);
        exp_t e;
        bit   got;
        start  = 1'b1;
        opcode = op;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        e.name = name;
        e.res  = er;
        e.ovf  = eo;
        e.dz   = ed;
        e.lat  = lat;
        e.e0   = cyc;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (intf && i == 1) begin
                start  = 1'b1;
                a      = 4'd1;
                b      = 4'd1;
                opcode = 3'b000;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk({name, "_timeout"}, 0, 1);
            exp_q.delete();
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        opcode = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", int'(result), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_dz", int'(dz), 0);
        reset = 1'b1;
        @(negedge clk);

        //     name        op      a      b      result  ovf   dz    L   intf
        run_op("add",      3'b000, 4'd9,  4'd7,  8'd16,  1'b0, 1'b0, 1,  1'b0);
        run_op("sub",      3'b001, 4'd3,  4'd5,  8'hFE,  1'b1, 1'b0, 1,  1'b0);
        run_op("op110",    3'b110, 4'd5,  4'd5,  8'd0,   1'b0, 1'b0, 1,  1'b0);
        run_op("div",      3'b010, 4'd13, 4'd4,  8'd3,   1'b0, 1'b0, 9,  1'b0);
        run_op("div_zero", 3'b010, 4'd13, 4'd0,  8'hFF,  1'b0, 1'b1, 1,  1'b0);
        run_op("mul",      3'b011, 4'd15, 4'd15, 8'd225, 1'b0, 1'b0, 5,  1'b0);
        run_op("mul_intf", 3'b011, 4'd15, 4'd15, 8'd225, 1'b0, 1'b0, 5,  1'b1);
        run_op("pct",      3'b101, 4'd15, 4'd15, 8'd2,   1'b0, 1'b0, 13, 1'b0);
        run_op("pow3_4",   3'b100, 4'd3,  4'd4,  8'd81,  1'b0, 1'b0, 5,  1'b0);
        run_op("pow0_0",   3'b100, 4'd0,  4'd0,  8'd1,   1'b0, 1'b0, 1,  1'b0);
        run_op("pow3_6",   3'b100, 4'd3,  4'd6,  8'd217, 1'b1, 1'b0, 7,  1'b0);

        // Abort a running pow with reset; no done may ever follow.
        start  = 1'b1;
        opcode = 3'b100;
        a      = 4'd3;
        b      = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("abort_result", int'(result), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ovf", int'(ovf), 0);
        chk("abort_dz", int'(dz), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_result", int'(result), 0);

        run_op("add_after_rst", 3'b000, 4'd2, 4'd2, 8'd4, 1'b0, 1'b0, 1, 1'b0);
        a = 4'd15;
        b = 4'd15;
        repeat (4) @(negedge clk);
        chk("hold_result", int'(result), 4);
        chk("hold_busy", int'(busy), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle arithmetic unit for the keypad calculator datapath: the next generation of the calculator ALU and power unit. It sits between the keypad controller and the result display. Operands are W bits wide, and results and intermediates are 2W bits wide. Multiply, divide, power and percent are computed iteratively behind a start/busy/done handshake, and the unit reports overflow, borrow and divide-by-zero flags.

## Interface
Parameters:
- W, default 4: operand width; legal range W >= 4, so that the constant 100 fits in RW bits.
- RW, default 2*W: result width; derived, never overridden.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request. Sampled only in IDLE.
- a, in, W: operand A / base / dividend.
- b, in, W: operand B / exponent / divisor.
- opcode, in, 3: operation select. 000 add, 001 sub, 010 div, 011 mul, 100 pow, 101 pct; 110/111 produce result 0.
- busy, out, 1: high whenever state != IDLE.
- done, out, 1: one-cycle pulse when result becomes valid.
- result, out, RW: final value; held until the next accepted start.
- ovf, out, 1: sub borrow (a < b), or pow product exceeded RW bits (sticky within the operation).
- dz, out, 1: div or pct divisor zero. For pct, dz is never set, because the divisor is the constant 100.

## Operation
- States: IDLE, MUL, DIV, POW, FIN.
- Operand capture:
  - At edge E0 with state IDLE and start=1, capture a, b and opcode, and clear ovf and dz.
  - Live inputs are ignored after E0.
  - start while busy=1, including the FIN cycle, is ignored.
- add/sub/110/111:
  - IDLE -> FIN. result is written at E1.
  - sub is RW-bit two's complement wrap; ovf=1 when a<b.
- mul:
  - Shift-add, one bit of b per cycle, W iterations in MUL, then FIN.
  - The product always fits in RW bits, so ovf=0.
- div:
  - b==0: IDLE -> FIN, result = all ones, dz=1.
  - Otherwise, the restoring divider runs RW iterations on the zero-extended operands; result = quotient.
- pow:
  - b==0: result=1, including 0^0.
  - Otherwise, acc starts at 1, and each POW cycle computes acc = acc*a, truncated to RW bits, for b cycles.
  - ovf is set if any untruncated product is >= 2^RW.
- pct:
  - result = (a*b)/100, truncated toward zero.
  - Runs MUL for W cycles, then DIV for RW cycles with divisor 100, then FIN.
- FIN:
  - done=1 for exactly one cycle.
  - Next edge returns to IDLE.
- Reset asserted (low), at any time including mid-operation:
  - Aborts the operation; state becomes IDLE.
  - result=0, done=0, busy=0, ovf=0, dz=0.
  - Divider and accumulator registers are cleared.

## Timing
- Latency L is counted in edges from E0 to the edge that raises done. result and flags change on that same edge.
  - add, sub, default, div-by-zero, pow with b=0: L=1.
  - mul: L=W+1.
  - div: L=RW+1.
  - pow: L=b+1.
  - pct: L=W+RW+1.
- busy rises at E0+1 and falls at E0+L+1. done is high only during the final busy cycle.
- Earliest back-to-back start is sampled at E0+L+1.
- result, ovf and dz are stable from E0+L until the next accepted start, or until reset.

## Structure
- Shared package seq_alu_pkg holds:
  - opcode localparams (OP_ADD through OP_PCT);
  - the state encoding;
  - PCT_DIVISOR = 100.
- Sub-module seq_div_core #(N):
  - Restoring divider with ports: start, dividend[N], divisor[N], quotient, remainder, done.
  - Exactly N iteration cycles.
  - Instantiated once with N=RW and shared by div and pct.
  - Inherits clk and the active-low asynchronous reset.
- Multiplier, power accumulator and FSM live in seq_alu. A single combinational RW x W multiply is shared by POW.

## Test plan
All scenarios use W=4, RW=8.
- add a=9 b=7 -> result=16, ovf=0, done one cycle at E0+1, busy high for exactly one cycle. sub a=3 b=5 -> result=8'hFE, ovf=1.
- div a=13 b=4 -> result=3, dz=0, done at E0+9. div a=13 b=0 -> result=8'hFF, dz=1, done at E0+1.
- mul a=15 b=15 -> result=225, done at E0+5. pct a=15 b=15 -> result=2, done at E0+13.
- pow:
  - a=3 b=4 -> result=81, ovf=0, done at E0+5.
  - a=3 b=6 -> result=217, ovf=1, done at E0+7.
  - a=0 b=0 -> result=1, done at E0+1.
- Mid-operation events:
  - start pulses with new operands during a running mul -> ignored; original result 225 returned.
  - reset driven low during pow a=3 b=6 -> all outputs 0 immediately. After release, add 2+2 -> result=4.
